// File: rtl/alu_result_display.sv
// ALU result display stage: binary result to two BCD digits (shift-add-3),
// multiplexed onto a shared seven-segment bus with a one-deep pending buffer.
module alu_result_display #(
   parameter int RES_W     = 6,
   parameter int REFRESH_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             res_valid,
   input  logic [RES_W-1:0] res_in,
   output logic             busy,
   output logic             done,
   output logic [7:0]       bcd_out,
   output logic [6:0]       seg,
   output logic [1:0]       dig_sel
);

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   localparam logic [2:0] LAST = 3'(RES_W - 1);

   state_t               state, state_d;
   logic [RES_W-1:0]     bin, pend, load_val;
   logic                 pend_v, load;
   logic [7:0]           scratch, adj;
   logic [2:0]           cnt;
   logic [REFRESH_W-1:0] refresh;
   logic [3:0]           digit;

   always_comb begin
      state_d  = state;
      load     = 1'b0;
      load_val = res_in;
      case (state)
         IDLE: begin
            if (res_valid) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST) state_d = UPDATE;
         end
         UPDATE: begin
            // a strobe landing now is newer than anything pending
            if (res_valid || pend_v) begin
               load     = 1'b1;
               load_val = res_valid ? res_in : pend;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      adj[3:0] = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
      adj[7:4] = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else if (ena) state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin     <= '0;
         scratch <= '0;
         cnt     <= '0;
         pend    <= '0;
         pend_v  <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         refresh <= '0;
         dig_sel <= 2'b01;
      end else if (ena) begin
         done <= (state == UPDATE);
         if (state == UPDATE) bcd_out <= scratch;

         if (load) begin
            bin     <= load_val;
            scratch <= '0;
            cnt     <= '0;
         end else if (state == SHIFT) begin
            {scratch, bin} <= {adj, bin} << 1;
            cnt            <= cnt + 3'd1;
         end

         if (state == UPDATE) begin
            pend_v <= 1'b0;
         end else if (res_valid && state != IDLE) begin
            pend_v <= 1'b1;
            pend   <= res_in;
         end

         refresh <= refresh + 1'b1;
         if (&refresh) dig_sel <= ~dig_sel;
      end
   end

   assign busy  = (state != IDLE);
   assign digit = dig_sel[1] ? bcd_out[7:4] : bcd_out[3:0];

   always_comb begin
      case (digit)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = 7'b0000000;
      endcase
      // leading-zero blanking on the tens digit
      if (dig_sel[1] && bcd_out[7:4] == 4'd0) seg = 7'b0000000;
   end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: stimulus pushes expected
// {bcd, done cycle}; a negedge monitor pops and compares on each done.
module tb_alu_result_display;

   localparam int RES_W = 6;
   localparam int LAT   = RES_W + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b1;
   logic             res_valid = 1'b0;
   logic [RES_W-1:0] res_in = '0;
   logic             busy, done;
   logic [7:0]       bcd_out;
   logic [6:0]       seg;
   logic [1:0]       dig_sel;

   typedef struct {
      logic [7:0] bcd;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   alu_result_display #(.RES_W(RES_W), .REFRESH_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .res_valid (res_valid),
      .res_in    (res_in),
      .busy      (busy),
      .done      (done),
      .bcd_out   (bcd_out),
      .seg       (seg),
      .dig_sel   (dig_sel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("bcd_out", int'(bcd_out), int'(e.bcd));
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // strobe v for one cycle; returns at the negedge right after the strobe edge
   task automatic strobe(input logic [RES_W-1:0] v, input logic [7:0] exp_bcd,
                         input int lat);
      @(negedge clk);
      res_valid = 1'b1;
      res_in    = v;
      q.push_back('{bcd: exp_bcd, cyc: cyc + 1 + lat});
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && (busy || q.size() != 0); i++) @(negedge clk);
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
   endtask

   task automatic check_seg(input logic [6:0] ones, input logic [6:0] tens);
      for (int i = 0; i < 10 && dig_sel != 2'b01; i++) @(negedge clk);
      check("seg_ones", int'(seg), int'(ones));
      for (int i = 0; i < 10 && dig_sel != 2'b10; i++) @(negedge clk);
      check("seg_tens", int'(seg), int'(tens));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] frozen;
      int k;

      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_bcd", int'(bcd_out), 'h00);
      check("rst_dig_sel", int'(dig_sel), 'b01);
      check("rst_seg", int'(seg), 'b0111111);
      @(negedge clk);
      rst_n = 1'b1;

      // 45: busy for exactly LAT cycles from the strobe edge
      strobe(6'd45, 8'h45, LAT);
      for (int i = 0; i < LAT; i++) begin
         check("busy_45", int'(busy), 1);
         @(negedge clk);
      end
      check("busy_45_end", int'(busy), 0);
      wait_idle();
      check_seg(7'b1101101, 7'b1100110);

      strobe(6'd7, 8'h07, LAT);
      wait_idle();
      check_seg(7'b0000111, 7'b0000000);

      strobe(6'd63, 8'h63, LAT);
      wait_idle();
      check_seg(7'b1001111, 7'b1111101);

      strobe(6'd0, 8'h00, LAT);
      wait_idle();
      check_seg(7'b0111111, 7'b0000000);

      // back-to-back: 12, then 20 and 34 while shifting; 20 is overwritten
      @(negedge clk);
      res_valid = 1'b1;
      res_in    = 6'd12;
      k = cyc + 1;
      q.push_back('{bcd: 8'h12, cyc: k + LAT});
      q.push_back('{bcd: 8'h34, cyc: k + 2 * LAT});
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         res_valid = (i == 2 || i == 4);
         res_in    = (i == 2) ? 6'd20 : 6'd34;
         check("busy_b2b", int'(busy), 1);
      end
      res_valid = 1'b0;
      @(negedge clk);
      check("busy_b2b_end", int'(busy), 0);
      wait_idle();

      // reset during the third shift of 50: no done, display back to 00
      @(negedge clk);
      res_valid = 1'b1;
      res_in    = 6'd50;
      @(negedge clk);
      res_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_bcd", int'(bcd_out), 'h00);
      check("abort_dig_sel", int'(dig_sel), 'b01);
      check("abort_seg", int'(seg), 'b0111111);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_bcd_after", int'(bcd_out), 'h00);
      check("abort_busy_after", int'(busy), 0);

      // ena low for 20 cycles mid-conversion; strobe while frozen is ignored
      strobe(6'd21, 8'h21, LAT + 20);
      @(negedge clk);
      @(negedge clk);
      ena    = 1'b0;
      frozen = dig_sel;
      for (int i = 0; i < 20; i++) begin
         res_valid = (i == 5);
         res_in    = 6'd9;
         @(negedge clk);
         check("frozen_dig_sel", int'(dig_sel), int'(frozen));
      end
      res_valid = 1'b0;
      ena       = 1'b1;
      wait_idle();
      check_seg(7'b0000110, 7'b1011011);

      repeat (LAT + 3) @(negedge clk);
      check("sb_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
